// File: rtl/spi_slave_loopback.sv
// SPI mode-0 slave, 8-bit MSB-first, oversampled by clk.
// MISO echoes the last complete byte received on MOSI.
module spi_slave_loopback #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SPI_CS,
   input  logic       SPI_Clk,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic       Rx_DV,
   output logic [7:0] Rx_Data
);

   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_prev_q;

   logic       sck_s, cs_s, mosi_s;
   logic       sck_rise, sck_fall;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic       done_q, done_d;
   logic       rx_dv_q, rx_dv_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic [7:0] loop_q, loop_d;
   logic [7:0] tx_shift_q, tx_shift_d;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   assign SPI_MISO = tx_shift_q[7];
   assign Rx_DV    = rx_dv_q;
   assign Rx_Data  = rx_data_q;

   // Input synchronisers plus SCK edge-detect register
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_Clk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
         sck_prev_q  <= sck_s;
      end
   end

   // Next-state: shift on SCK edges, publish byte one cycle after bit 8
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      done_d     = 1'b0;
      rx_dv_d    = 1'b0;
      rx_data_d  = rx_data_q;
      loop_d     = loop_q;
      tx_shift_d = tx_shift_q;
      if (cs_s) begin
         bit_cnt_d  = 3'd0;
         tx_shift_d = loop_q;
      end else begin
         if (sck_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            done_d     = (bit_cnt_q == 3'd7);
         end
         if (sck_fall && bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
         end
      end
      if (done_q) begin
         rx_dv_d    = 1'b1;
         rx_data_d  = rx_shift_q;
         loop_d     = rx_shift_q;
         tx_shift_d = rx_shift_q;
      end
   end

   // Frame state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_q  <= 3'd0;
         rx_shift_q <= 8'h00;
         done_q     <= 1'b0;
         rx_dv_q    <= 1'b0;
         rx_data_q  <= 8'h00;
         loop_q     <= 8'h00;
         tx_shift_q <= 8'h00;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         done_q     <= done_d;
         rx_dv_q    <= rx_dv_d;
         rx_data_q  <= rx_data_d;
         loop_q     <= loop_d;
         tx_shift_q <= tx_shift_d;
      end
   end

endmodule

// File: tb/tb_spi_slave_loopback.sv
// Directed bench for spi_slave_loopback.
// SPI master timing: 400 ns half-period, 80 ns CS setup.
module tb_spi_slave_loopback;

   logic       clk;
   logic       reset;
   logic       SPI_CS;
   logic       SPI_Clk;
   logic       SPI_MOSI;
   logic       SPI_MISO;
   logic       Rx_DV;
   logic [7:0] Rx_Data;

   int checks;
   int failures;
   int dv_cnt;
   int dv_base;
   logic [7:0] r;

   spi_slave_loopback #(.SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .SPI_CS   (SPI_CS),
      .SPI_Clk  (SPI_Clk),
      .SPI_MOSI (SPI_MOSI),
      .SPI_MISO (SPI_MISO),
      .Rx_DV    (Rx_DV),
      .Rx_Data  (Rx_Data)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // Count clk cycles with Rx_DV high
   always @(negedge clk) begin
      if (Rx_DV) dv_cnt <= dv_cnt + 1;
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] b, input int nbits,
                       input int dly0, output logic [7:0] rd);
      rd = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         SPI_MOSI = b[7-i];
         if (i == 0) #(dly0);
         else #400;
         SPI_Clk = 1'b1;
         rd = {rd[6:0], SPI_MISO};
         #400;
         SPI_Clk = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] b, output logic [7:0] rd);
      SPI_CS = 1'b0;
      xfer(b, 8, 80, rd);
      #400;
      SPI_CS = 1'b1;
      #400;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      dv_cnt   = 0;
      reset    = 1'b1;
      SPI_CS   = 1'b1;
      SPI_Clk  = 1'b0;
      SPI_MOSI = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_dv", {7'd0, Rx_DV}, 8'h00);
      chk("rst_data", Rx_Data, 8'h00);
      chk("rst_miso", {7'd0, SPI_MISO}, 8'h00);

      // 1: first frame echoes reset value
      dv_base = dv_cnt;
      frame(8'hC1, r);
      chk("t1_miso", r, 8'h00);
      chk("t1_data", Rx_Data, 8'hC1);
      chk("t1_dv", 8'(dv_cnt - dv_base), 8'd1);
      chk("t1_idle_miso", {7'd0, SPI_MISO}, 8'h01);

      // 2: two framed bytes
      dv_base = dv_cnt;
      frame(8'hBE, r);
      chk("t2_miso_a", r, 8'hC1);
      frame(8'hEF, r);
      chk("t2_miso_b", r, 8'hBE);
      chk("t2_data", Rx_Data, 8'hEF);
      chk("t2_dv", 8'(dv_cnt - dv_base), 8'd2);

      // 3: back-to-back with zero-width CS pulse, then without
      dv_base = dv_cnt;
      SPI_CS = 1'b0;
      xfer(8'hA1, 8, 80, r);
      chk("t3_miso_a", r, 8'hEF);
      SPI_CS = 1'b1;
      SPI_CS = 1'b0;
      xfer(8'h5C, 8, 400, r);
      chk("t3_miso_b", r, 8'hA1);
      chk("t3_data_b", Rx_Data, 8'h5C);
      xfer(8'h25, 8, 400, r);
      chk("t3_miso_c", r, 8'h5C);
      xfer(8'h38, 8, 400, r);
      chk("t3_miso_d", r, 8'h25);
      #400;
      SPI_CS = 1'b1;
      #400;
      chk("t3_data", Rx_Data, 8'h38);
      chk("t3_dv", 8'(dv_cnt - dv_base), 8'd4);

      // 4: partial byte aborted by CS
      dv_base = dv_cnt;
      SPI_CS = 1'b0;
      xfer(8'hF0, 4, 80, r);
      #400;
      SPI_CS = 1'b1;
      #400;
      chk("t4_part_dv", 8'(dv_cnt - dv_base), 8'd0);
      chk("t4_part_data", Rx_Data, 8'h38);
      frame(8'h3C, r);
      chk("t4_miso", r, 8'h38);
      chk("t4_data", Rx_Data, 8'h3C);
      chk("t4_dv", 8'(dv_cnt - dv_base), 8'd1);

      // 5: reset mid-frame
      SPI_CS = 1'b0;
      xfer(8'hAA, 5, 80, r);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_rst_data", Rx_Data, 8'h00);
      chk("t5_rst_miso", {7'd0, SPI_MISO}, 8'h00);
      SPI_CS = 1'b1;
      #400;
      dv_base = dv_cnt;
      frame(8'h81, r);
      chk("t5_miso", r, 8'h00);
      chk("t5_data", Rx_Data, 8'h81);
      chk("t5_dv", 8'(dv_cnt - dv_base), 8'd1);

      // 6: SCK toggling with CS high is ignored
      dv_base = dv_cnt;
      for (int i = 0; i < 8; i++) begin
         SPI_MOSI = i[0];
         SPI_Clk = 1'b1;
         #400;
         SPI_Clk = 1'b0;
         #400;
      end
      chk("t6_dv", 8'(dv_cnt - dv_base), 8'd0);
      chk("t6_data", Rx_Data, 8'h81);
      chk("t6_miso", {7'd0, SPI_MISO}, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
